// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the branch clock-enable controller.
// Optional feature macro used by this slice: CLK_GATE_STATS_EN (wake counter).
package clk_gate_pkg;

    // Controller states; the encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        CG_OFF  = 2'd0,
        CG_WAKE = 2'd1,
        CG_ON   = 2'd2,
        CG_IDLE = 2'd3
    } cg_state_t;

    localparam logic [1:0] CG_ENC_OFF  = 2'd0;
    localparam logic [1:0] CG_ENC_WAKE = 2'd1;
    localparam logic [1:0] CG_ENC_ON   = 2'd2;
    localparam logic [1:0] CG_ENC_IDLE = 2'd3;

    localparam int unsigned WAKE_CNT_W = 16;

    // Width needed to hold the larger of the two timer reload values.
    function automatic int unsigned cg_timer_width(input int unsigned wake_cyc,
                                                   input int unsigned idle_cyc);
        int unsigned m;
        m = (wake_cyc > idle_cyc) ? wake_cyc : idle_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Requester-side bundle of the clock-enable controller.
// With CLK_GATE_STATS_EN defined the bundle also carries wake_cnt.
interface clk_gate_ctrl_if #(
    parameter int unsigned N_REQ = 4
);
    import clk_gate_pkg::*;

    logic [N_REQ-1:0] req;
    logic             force_on;
    logic [N_REQ-1:0] ack;
    logic             gate_en;
    logic [1:0]       state;
`ifdef CLK_GATE_STATS_EN
    logic [WAKE_CNT_W-1:0] wake_cnt;
`endif

    // Requesters drive demand and observe grants.
    modport master (
        output req,
        output force_on,
        input  ack,
        input  gate_en,
        input  state
`ifdef CLK_GATE_STATS_EN
        ,
        input  wake_cnt
`endif
    );

    // Controller consumes demand and drives grants.
    modport slave (
        input  req,
        input  force_on,
        output ack,
        output gate_en,
        output state
`ifdef CLK_GATE_STATS_EN
        ,
        output wake_cnt
`endif
    );

endinterface

// File: rtl/clk_gate_timer.sv
// Loadable down-counter shared by the wake settle and idle hysteresis phases.
module clk_gate_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; the count parks at zero and never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-enable controller for a shared gated branch clock.
// Requests are acked only after a wake settle time; after demand drops the
// clock is held on for an idle hysteresis before gating off.
// Optional: CLK_GATE_STATS_EN adds a saturating OFF->WAKE counter (wake_cnt).
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WAKE_CYC = 2,
    parameter int unsigned IDLE_CYC = 16
) (
    input  logic             mclk,
    input  logic             rst_n,
    clk_gate_ctrl_if.slave   bus
);

    localparam int unsigned TMR_W = cg_timer_width(WAKE_CYC, IDLE_CYC);

    cg_state_t        state_q;
    cg_state_t        state_d;
    logic [N_REQ-1:0] ack_q;
    logic [N_REQ-1:0] ack_d;
    logic             gate_en_q;
    logic             gate_en_d;

    logic             dem;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;

    clk_gate_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (mclk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next-state, timer control and registered-output inputs.
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        dem          = (|bus.req) | bus.force_on;

        unique case (state_q)
            CG_OFF: begin
                if (dem) begin
                    state_d      = CG_WAKE;
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(WAKE_CYC - 1);
                end
            end
            CG_WAKE: begin
                // Settle always completes; a vanished request is handled from ON.
                if (tmr_zero) begin
                    state_d = CG_ON;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CG_ON: begin
                if (!dem) begin
                    state_d      = CG_IDLE;
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(IDLE_CYC - 1);
                end
            end
            CG_IDLE: begin
                // Returning demand beats expiry, even on the last idle cycle.
                if (dem) begin
                    state_d = CG_ON;
                end else if (tmr_zero) begin
                    state_d = CG_OFF;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = CG_OFF;
            end
        endcase

        ack_d     = (state_d == CG_ON) ? bus.req : '0;
        gate_en_d = (state_d != CG_OFF);
    end

    // State and output registers.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CG_OFF;
            ack_q     <= '0;
            gate_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            gate_en_q <= gate_en_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.gate_en = gate_en_q;
    assign bus.state   = state_q;

`ifdef CLK_GATE_STATS_EN
    logic [WAKE_CNT_W-1:0] wake_cnt_q;
    logic [WAKE_CNT_W-1:0] wake_cnt_d;

    // Count cold wakes, saturating at all-ones.
    always_comb begin
        wake_cnt_d = wake_cnt_q;
        if ((state_q == CG_OFF) && (state_d == CG_WAKE) && (wake_cnt_q != '1)) begin
            wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1);
        end
    end

    // Wake counter register.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            wake_cnt_q <= '0;
        end else begin
            wake_cnt_q <= wake_cnt_d;
        end
    end

    assign bus.wake_cnt = wake_cnt_q;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios plus randomized
// traffic against a timing-level model of the clock branch.
// Build with CLK_GATE_STATS_EN defined to also check wake_cnt.
module tb_clk_gate_ctrl;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned WAKE_CYC = 2;
    localparam int unsigned IDLE_CYC = 16;

    logic mclk;
    logic rst_n;

    int n_tests;
    int n_fail;

    clk_gate_ctrl_if #(.N_REQ(N_REQ)) bus ();

    clk_gate_ctrl #(
        .N_REQ    (N_REQ),
        .WAKE_CYC (WAKE_CYC),
        .IDLE_CYC (IDLE_CYC)
    ) dut (
        .mclk  (mclk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Reference model: is the branch running, has it settled, how long since
    // demand was last seen, and how many cold starts happened.
    bit               m_on;
    bit               m_stable;
    int               m_wake_left;
    int               m_quiet;
    logic [N_REQ-1:0] m_ack;
    int               m_wakes;

    function automatic logic [1:0] m_state();
        if (!m_on)          return 2'd0;
        if (!m_stable)      return 2'd1;
        if (m_quiet == 0)   return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [15:0] m_wcnt();
        return (m_wakes > 65535) ? 16'hFFFF : 16'(m_wakes);
    endfunction

    task automatic model_reset();
        m_on = 0; m_stable = 0; m_wake_left = 0; m_quiet = 0; m_ack = '0; m_wakes = 0;
    endtask

    task automatic model_update();
        bit dem;
        dem   = (|bus.req) | bus.force_on;
        m_ack = '0;
        if (!m_on) begin
            if (dem) begin
                m_on = 1; m_stable = 0; m_wake_left = WAKE_CYC; m_wakes++;
            end
        end else if (!m_stable) begin
            m_wake_left--;
            if (m_wake_left == 0) begin
                m_stable = 1; m_quiet = 0; m_ack = bus.req;
            end
        end else if (dem) begin
            m_quiet = 0; m_ack = bus.req;
        end else begin
            m_quiet++;
            if (m_quiet > IDLE_CYC) begin
                m_on = 0; m_stable = 0; m_quiet = 0;
            end
        end
    endtask

    // One clock edge; the model follows the same sampled inputs.
    task automatic tick();
        @(posedge mclk);
        if (!rst_n) model_reset();
        else        model_update();
        #1;
    endtask

    // Drop demand and let the branch gate off.
    task automatic drain_to_off();
        int k;
        bus.req = '0; bus.force_on = 1'b0;
        k = 0;
        while (!(bus.state === 2'd0 && bus.gate_en === 1'b0) && k < 100) begin
            tick(); k++;
        end
        n_tests++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL drain_timeout: state=%0d gate_en=%b, required state=0 gate_en=0", bus.state, bus.gate_en);
        end
    endtask

    // Raise requests and wait for the branch to reach ON.
    task automatic bring_on(input logic [N_REQ-1:0] r);
        int k;
        bus.req = r;
        k = 0;
        while (bus.state !== 2'd2 && k < 50) begin
            tick(); k++;
        end
        n_tests++;
        if (k >= 50) begin
            n_fail++;
            $display("FAIL bring_on_timeout: state=%0d, required 2", bus.state);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.req = 4'hF; bus.force_on = 1'b0;
        model_reset();
        repeat (3) tick();
        n_tests++;
        if (bus.gate_en !== 1'b0 || bus.ack !== 4'h0 || bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold: gate_en=%b ack=%h state=%0d, required 0/0/0", bus.gate_en, bus.ack, bus.state);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (bus.state !== 2'd1 || bus.gate_en !== 1'b1 || bus.ack !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_release: state=%0d gate_en=%b ack=%h, required 1/1/0", bus.state, bus.gate_en, bus.ack);
        end
        drain_to_off();
    endtask

    task automatic test_cold_wake();
        logic [N_REQ-1:0] exp_ack;
        bus.req = 4'b0001;
        for (int i = 1; i <= int'(WAKE_CYC) + 1; i++) begin
            tick();
            exp_ack = (i == int'(WAKE_CYC) + 1) ? 4'b0001 : 4'b0000;
            n_tests++;
            if (bus.gate_en !== 1'b1 || bus.ack !== exp_ack) begin
                n_fail++;
                $display("FAIL cold_wake edge %0d: gate_en=%b ack=%b, required 1 %b", i, bus.gate_en, bus.ack, exp_ack);
            end
        end
    endtask

    task automatic test_hysteresis();
        int off_edge;
        bus.req = '0;
        off_edge = -1;
        for (int i = 1; i <= 40 && off_edge < 0; i++) begin
            tick();
            if (bus.gate_en === 1'b0) off_edge = i;
        end
        n_tests++;
        if (off_edge != int'(IDLE_CYC) + 1) begin
            n_fail++;
            $display("FAIL hysteresis_gate_off: gate_en fell after %0d edges, required %0d", off_edge, IDLE_CYC + 1);
        end
    endtask

    task automatic test_reentry();
        bit dropped;
        bring_on(4'b0001);
        bus.req = '0;
        dropped = 0;
        for (int i = 0; i < int'(IDLE_CYC); i++) begin
            tick();
            if (bus.gate_en !== 1'b1) dropped = 1;
        end
        n_tests++;
        if (bus.state !== 2'd3 || dropped) begin
            n_fail++;
            $display("FAIL reentry_idle_end: state=%0d dropped=%0d, required state=3 dropped=0", bus.state, dropped);
        end
        bus.req = 4'b0100;
        tick();
        n_tests++;
        if (bus.state !== 2'd2 || bus.ack !== 4'b0100 || bus.gate_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reentry_on: state=%0d ack=%b gate_en=%b, required 2 0100 1", bus.state, bus.ack, bus.gate_en);
        end
        drain_to_off();
    endtask

    task automatic test_force_on();
        bus.force_on = 1'b1; bus.req = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_tests++;
            if (bus.gate_en !== 1'b1 || bus.ack !== 4'h0) begin
                n_fail++;
                $display("FAIL force_on_hold cycle %0d: gate_en=%b ack=%h, required 1 0", i, bus.gate_en, bus.ack);
            end
        end
        bus.req = 4'b0010;
        tick();
        n_tests++;
        if (bus.ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL force_on_join: ack=%b, required 0010", bus.ack);
        end
        drain_to_off();
    endtask

    task automatic test_random();
        logic [N_REQ-1:0] r;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) begin
                r = N_REQ'($urandom);
                if ($urandom_range(2) == 0) r = '0;
                bus.req = r;
            end
            if ($urandom_range(31) == 0) bus.force_on = ~bus.force_on;
            if ($urandom_range(63) == 0) begin
                // long quiet stretch so the branch actually gates off
                bus.req = '0; bus.force_on = 1'b0;
            end
            tick();
            n_tests++;
            if (bus.gate_en !== m_on || bus.ack !== m_ack || bus.state !== m_state()) begin
                n_fail++;
                $display("FAIL random cycle %0d: gate_en=%b ack=%b state=%0d, required %b %b %0d",
                         i, bus.gate_en, bus.ack, bus.state, m_on, m_ack, m_state());
            end
`ifdef CLK_GATE_STATS_EN
            n_tests++;
            if (bus.wake_cnt !== m_wcnt()) begin
                n_fail++;
                $display("FAIL random_wake_cnt cycle %0d: wake_cnt=%0d, required %0d", i, bus.wake_cnt, m_wcnt());
            end
`endif
        end
        drain_to_off();
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bring_on(4'b1000);
            drain_to_off();
        end
`ifdef CLK_GATE_STATS_EN
        n_tests++;
        if (bus.wake_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL stats_three_wakes: wake_cnt=%0d, required 3", bus.wake_cnt);
        end
`endif
        bring_on(4'b0110);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (bus.gate_en !== 1'b0 || bus.ack !== 4'h0 || bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset_mid_on: gate_en=%b ack=%h state=%0d, required 0/0/0", bus.gate_en, bus.ack, bus.state);
        end
`ifdef CLK_GATE_STATS_EN
        n_tests++;
        if (bus.wake_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset_wake_cnt: wake_cnt=%0d, required 0", bus.wake_cnt);
        end
`endif
        bus.req = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; bus.req = '0; bus.force_on = 1'b0;
        model_reset();
        test_reset();
        test_cold_wake();
        test_hysteresis();
        test_reentry();
        test_force_on();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Clock-enable controller for a shared gated branch clock derived from `mclk`. Up to `N_REQ` requesters ask for the branch clock over a req/ack handshake. The block asserts `gate_en` toward the branch clock-gate/buffer stage and acknowledges a requester only after a fixed wake-up settle time. After all requests drop, it holds the clock on for a programmable idle hysteresis before gating it off.

## Interface
- `N_REQ`, 4, number of requesters (1..16)
- `WAKE_CYC`, 2, `mclk` cycles between `gate_en` rising and first ack (≥1)
- `IDLE_CYC`, 16, `mclk` cycles of no demand before `gate_en` falls (≥1)
- `mclk` input 1 master clock; all logic on rising edge
- `rst_n` input 1 asynchronous active-low reset
- `req` input `N_REQ` per-requester clock request, level, held until ack seen and work done
- `force_on` input 1 keeps branch clock on regardless of `req`; never acked
- `ack` output `N_REQ` registered grant: branch clock stable and on for requester i
- `gate_en` output 1 registered enable to branch clock gate
- `state` output 2 current FSM state (debug)

## Operation
- Demand `dem = |req | force_on`.
- States (encoding): OFF=0, WAKE=1, ON=2, IDLE=3.
- OFF: `gate_en`=0, `ack`=0. If `dem`, go to WAKE and load timer with `WAKE_CYC-1`.
- WAKE: `gate_en`=1. Timer decrements each cycle; at 0, go to ON. Always completes, even if `dem` drops (no abort).
- ON: `gate_en`=1. If `!dem`, go to IDLE and load timer with `IDLE_CYC-1`.
- IDLE: `gate_en`=1. If `dem`, return to ON with no wake penalty. Else the timer decrements; at 0, go to OFF.
- Ack rule: registered `ack <= (next_state==ON) ? req : 0`. Each ack bit is independent; a new requester joining during ON or IDLE is acked next cycle.
- `gate_en` is registered: `gate_en <= (next_state != OFF)`.
- Timer width: `$clog2(max(WAKE_CYC,IDLE_CYC)+1)`. It never wraps; it only loads on entry and decrements toward 0.

## Timing
- Reset (async assert, sync release): state=OFF, `gate_en`=0, `ack`=0, timer=0. Reset mid-ON drops `gate_en` and `ack` immediately.
- Wake latency: `req` high at edge t while OFF → `gate_en`=1 after edge t+1, `ack`=1 after edge t+1+`WAKE_CYC`.
- ON latency: `req[i]` rise → `ack[i]` after 1 edge; `req[i]` fall → `ack[i]` falls after 1 edge.
- Gate-off: last demand falls at edge t → IDLE after t+1 → `gate_en`=0 after edge t+1+`IDLE_CYC`.
- Demand returning on the final IDLE cycle (timer=0): `dem` wins, go to ON, `gate_en` stays 1.
- Simultaneous rise of several `req` bits is acked in the same cycle. There is no arbitration: the clock is a shared, non-exclusive resource.

## Configuration
- `CLK_GATE_STATS_EN` defined: adds output `wake_cnt[15:0]`. It increments on each OFF→WAKE transition, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

## Structure
- Package `clk_gate_pkg`:
  - `typedef enum logic [1:0] cg_state_t {CG_OFF, CG_WAKE, CG_ON, CG_IDLE}`
  - encoding constants
- Sub-module `clk_gate_timer`: loadable down-counter with `load`, `load_val`, `dec`, and a `zero` flag. Parameterized width. Shared by WAKE and IDLE.

## Test plan
- Reset: hold `rst_n`=0 with `req`=4'hF → `gate_en`=0, `ack`=0, `state`=0. Release → WAKE next cycle.
- Cold wake: `req`=4'b0001 at cycle 10 (OFF) → `gate_en`=1 from cycle 11, `ack`=4'b0001 from cycle 13 (`WAKE_CYC`=2).
- Hysteresis: drop all `req` at cycle 50 → `gate_en` stays 1 through cycle 66, 0 at 67 (`IDLE_CYC`=16).
- Re-entry: `req[2]` rises during IDLE at timer=0 → state ON, `ack[2]` next cycle, `gate_en` never drops.
- `force_on`: `force_on`=1 with `req`=0 → `gate_en`=1 indefinitely, `ack`=0. Then `req[1]`=1 → `ack[1]` one cycle later.
- Stats (`CLK_GATE_STATS_EN`): 3 full OFF→ON→OFF cycles → `wake_cnt`=3. Async reset mid-ON → `wake_cnt`=0, `gate_en`=0 immediately.
